irq_pending_ctrl: RTL and testbench
===================================

IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 15, number of cycles irq stays high without irq_ack before abandoning the request (range 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: req_in  input  4  request lines, synchronous to clk; a 0->1 transition is an event; bit 3 has highest priority.
REQ-005 Port: mask  input  4  1 = bit excluded from arbitration; pending state is still kept.
REQ-006 Port: irq_ack  input  1  consumer accepts the presented irq_id.
REQ-007 Port: eoi  input  1  consumer finished servicing the acknowledged request.
REQ-008 Port: irq  output  1  request presented to consumer.
REQ-009 Port: irq_id  output  2  index of the presented request.
REQ-010 Port: pending  output  4  sticky pending register.
REQ-011 Port: in_service  output  1  high between accepted ack and eoi.
REQ-012 Port: timeout_err  output  1  one-cycle pulse when ACK_TIMEOUT expires.

Function
REQ-013 req_in shall be registered into req_q; pending[i] shall set on the edge where req_in[i]=1 and req_q[i]=0.
REQ-014 Level-high req_in shall not re-set a cleared pending bit until it returns to 0 and rises again.
REQ-015 Effective requests: pending & ~mask, priority-encoded with bit 3 highest.
REQ-016 FSM states: IDLE, ASSERT, SERVICE; all outputs registered or decoded from state plus latched id.
REQ-017 IDLE: if any effective bit is set, latch the highest effective index into irq_id and go to ASSERT; otherwise stay.
REQ-018 Latency: req_in rising sampled at edge k -> pending set after k -> irq=1 after edge k+1.
REQ-019 ASSERT: irq=1; irq_id shall hold constant even if mask or pending change.
REQ-020 ASSERT with irq_ack=1: clear pending[irq_id], go to SERVICE, irq=0 on the next cycle.
REQ-021 Timeout counter: cleared on entry to ASSERT and incremented each ASSERT cycle without ack; irq stays high exactly ACK_TIMEOUT cycles.
REQ-022 On expiry, timeout_err pulses for one cycle and the FSM returns to IDLE with pending[irq_id] left set.
REQ-023 An ack in the final ASSERT cycle wins over timeout: no timeout_err pulse.
REQ-024 SERVICE: in_service=1; eoi=1 goes to IDLE; there is no nesting, and new events only accumulate in pending.
REQ-025 irq_ack outside ASSERT and eoi outside SERVICE shall be ignored.
REQ-026 If a new event on bit i coincides with the ack-clear of bit i, set wins and pending[i] stays 1.
REQ-027 IDLE re-arbitrates on the cycle after return, so back-to-back requests incur one IDLE cycle.

Reset
REQ-028 While rst_n=0, the block shall immediately hold pending=0, req_q=0, state=IDLE, irq=0, irq_id=0, in_service=0, timeout_err=0, counter=0.
REQ-029 Reset mid-ASSERT or mid-SERVICE shall discard all pending state without emitting a timeout_err pulse.
REQ-030 Deassertion of rst_n shall take effect synchronously to clk; events are detected from the first edge after release.

Structure
REQ-031 A shared package shall hold the FSM state encoding (IDLE=0, ASSERT=1, SERVICE=2), the NUM_REQ=4 constant and the counter width derived from ACK_TIMEOUT.
REQ-032 The priority selection shall be one combinational sub-module, prio_enc4 (inputs: effective[3:0]; outputs: index[1:0], any_valid).

Verification
REQ-033 Scenario: req_in=0001 at edge k, mask=0 -> irq=1 and irq_id=0 after k+1; ack -> pending=0000 and in_service=1; eoi -> IDLE.
REQ-034 Scenario: req_in=1010 simultaneously -> irq_id=3 first; after ack+eoi, irq_id=1 follows after one IDLE cycle.
REQ-035 Scenario: mask=1000 with pending=1001 -> irq_id=0; bit 3 stays pending and is presented once mask=0000.
REQ-036 Scenario: no ack with ACK_TIMEOUT=4 -> irq high exactly 4 cycles, timeout_err high 1 cycle, pending unchanged, irq reasserts later.
REQ-037 Scenario: bit 2 rises again in the same cycle its ack clears it -> pending[2] remains 1.
REQ-038 Scenario: rst_n=0 mid-SERVICE -> all outputs 0 immediately; req_in held high after release produces no event until it toggles.

Source files
------------

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared definitions for the interrupt pending controller: FSM encoding,
// request count and timeout-counter sizing.
package irq_pending_ctrl_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Counter only needs to reach ACK_TIMEOUT-1, the value of the last ASSERT cycle.
  function automatic int cnt_width(input int ack_timeout);
    return (ack_timeout <= 2) ? 1 : $clog2(ack_timeout);
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_prio_enc4.sv
// Four-input priority encoder; bit 3 has the highest priority.
module prio_enc4 (
  input  logic [3:0] effective,
  output logic [1:0] index,
  output logic       any_valid
);

  always_comb begin
    index     = 2'd0;
    any_valid = 1'b1;
    if (effective[3])      index = 2'd3;
    else if (effective[2]) index = 2'd2;
    else if (effective[1]) index = 2'd1;
    else if (effective[0]) index = 2'd0;
    else                   any_valid = 1'b0;
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky edge-triggered interrupt pending register with a single-outstanding
// present/acknowledge/service handshake and an acknowledge timeout.
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_in,
  input  logic [3:0] mask,
  input  logic       irq_ack,
  input  logic       eoi,
  output logic       irq,
  output logic [1:0] irq_id,
  output logic [3:0] pending,
  output logic       in_service,
  output logic       timeout_err
);

  localparam int CNT_W = cnt_width(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t               state;
  logic [NUM_REQ-1:0]   req_q;
  logic                 armed;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_REQ-1:0]   rise;
  logic [NUM_REQ-1:0]   effective;
  logic [NUM_REQ-1:0]   ack_clr;
  logic [1:0]           sel_index;
  logic                 sel_valid;
  logic                 ack_taken;

  // The first edge after reset only captures the request levels, so a line
  // already high when reset releases does not count as an event.
  assign rise      = armed ? (req_in & ~req_q) : '0;
  assign effective = pending & ~mask;
  assign ack_taken = (state == ASSERT) && irq_ack;
  assign ack_clr   = ack_taken ? (NUM_REQ'(1) << irq_id) : '0;

  prio_enc4 u_prio_enc4 (
    .effective (effective),
    .index     (sel_index),
    .any_valid (sel_valid)
  );

  assign irq        = (state == ASSERT);
  assign in_service = (state == SERVICE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      armed       <= 1'b0;
      pending     <= '0;
      state       <= IDLE;
      irq_id      <= 2'd0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      req_q       <= req_in;
      armed       <= 1'b1;
      timeout_err <= 1'b0;
      // A new event on the bit being acknowledged survives the clear.
      pending     <= (pending & ~ack_clr) | rise;

      case (state)
        IDLE: begin
          if (sel_valid) begin
            irq_id <= sel_index;
            cnt    <= '0;
            state  <= ASSERT;
          end
        end
        ASSERT: begin
          if (irq_ack) begin
            state <= SERVICE;
          end else if (cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SERVICE: begin
          if (eoi) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed scenarios followed by random traffic, checked cycle by cycle
// against a behavioural model of the pending/present/service rules.
module tb_irq_pending_ctrl;

  localparam int T = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic       irq_ack;
  logic       eoi;
  logic       irq;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic       in_service;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [3:0] m_pend;
  logic [3:0] m_prev;
  bit         m_armed;
  bit         m_serv;
  bit         m_terr;
  int         m_left;   // remaining cycles irq stays up; 0 = not presenting
  int         m_id;

  irq_pending_ctrl #(.ACK_TIMEOUT(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_in      (req_in),
    .mask        (mask),
    .irq_ack     (irq_ack),
    .eoi         (eoi),
    .irq         (irq),
    .irq_id      (irq_id),
    .pending     (pending),
    .in_service  (in_service),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_prev  = '0;
    m_armed = 0;
    m_serv  = 0;
    m_terr  = 0;
    m_left  = 0;
    m_id    = 0;
  endtask

  task automatic model_update(input logic [3:0] r, input logic [3:0] msk,
                              input logic a, input logic e);
    logic [3:0] rise;
    logic [3:0] nxt;
    int hit;
    rise    = m_armed ? (r & ~m_prev) : 4'b0000;
    m_prev  = r;
    m_armed = 1;
    nxt     = m_pend;
    m_terr  = 0;
    if (m_left > 0) begin
      if (a) begin
        nxt[m_id] = 1'b0;
        m_left    = 0;
        m_serv    = 1;
      end else if (m_left == 1) begin
        m_left = 0;
        m_terr = 1;
      end else begin
        m_left = m_left - 1;
      end
    end else if (m_serv) begin
      if (e) m_serv = 0;
    end else begin
      hit = -1;
      for (int i = 3; i >= 0; i--)
        if (hit < 0 && m_pend[i] && !msk[i]) hit = i;
      if (hit >= 0) begin
        m_id   = hit;
        m_left = T;
      end
    end
    m_pend = nxt | rise;
  endtask

  task automatic compare_all();
    chk("irq",         8'(irq),         8'(m_left > 0));
    chk("irq_id",      8'(irq_id),      8'(m_id));
    chk("pending",     8'(pending),     8'(m_pend));
    chk("in_service",  8'(in_service),  8'(m_serv));
    chk("timeout_err", 8'(timeout_err), 8'(m_terr));
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] msk,
                      input logic a, input logic e);
    req_in  = r;
    mask    = msk;
    irq_ack = a;
    eoi     = e;
    @(posedge clk);
    model_update(r, msk, a, e);
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] msk;
    rst_n   = 1'b0;
    req_in  = '0;
    mask    = '0;
    irq_ack = 1'b0;
    eoi     = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request, ack, eoi
    step(4'b0000, 4'b0000, 0, 0);
    step(4'b0001, 4'b0000, 0, 0);
    chk("s1_pend_set", 8'(pending), 8'h01);
    chk("s1_irq_low_k", 8'(irq), 8'h00);
    step(4'b0001, 4'b0000, 0, 0);
    chk("s1_irq_k1", 8'(irq), 8'h01);
    chk("s1_id", 8'(irq_id), 8'h00);
    step(4'b0001, 4'b0000, 1, 0);
    chk("s1_pend_clr", 8'(pending), 8'h00);
    chk("s1_in_service", 8'(in_service), 8'h01);
    step(4'b0001, 4'b0000, 0, 1);
    chk("s1_eoi", 8'(in_service), 8'h00);

    // Two simultaneous requests: priority then one IDLE cycle
    step(4'b0000, 4'b0000, 0, 0);
    step(4'b1010, 4'b0000, 0, 0);
    step(4'b1010, 4'b0000, 0, 0);
    chk("s2_first_id", 8'(irq_id), 8'h03);
    step(4'b1010, 4'b0000, 1, 0);
    step(4'b1010, 4'b0000, 0, 1);
    chk("s2_idle_gap", 8'(irq), 8'h00);
    step(4'b1010, 4'b0000, 0, 0);
    chk("s2_second_irq", 8'(irq), 8'h01);
    chk("s2_second_id", 8'(irq_id), 8'h01);
    step(4'b1010, 4'b0000, 1, 0);
    step(4'b1010, 4'b0000, 0, 1);

    // Masked high-priority bit stays pending until unmasked
    step(4'b0000, 4'b1000, 0, 0);
    step(4'b1001, 4'b1000, 0, 0);
    step(4'b1001, 4'b1000, 0, 0);
    chk("s3_masked_id", 8'(irq_id), 8'h00);
    step(4'b1001, 4'b1000, 1, 0);
    step(4'b1001, 4'b1000, 0, 1);
    step(4'b1001, 4'b1000, 0, 0);
    chk("s3_held_irq", 8'(irq), 8'h00);
    chk("s3_held_pend", 8'(pending), 8'h08);
    step(4'b1001, 4'b0000, 0, 0);
    chk("s3_unmask_id", 8'(irq_id), 8'h03);
    step(4'b1001, 4'b0000, 1, 0);
    step(4'b1001, 4'b0000, 0, 1);

    // Acknowledge timeout
    step(4'b0000, 4'b0000, 0, 0);
    step(4'b0100, 4'b0000, 0, 0);
    for (int i = 0; i < T; i++) begin
      step(4'b0100, 4'b0000, 0, 0);
      chk("s4_irq_high", 8'(irq), 8'h01);
    end
    step(4'b0100, 4'b0000, 0, 0);
    chk("s4_irq_drop", 8'(irq), 8'h00);
    chk("s4_terr", 8'(timeout_err), 8'h01);
    chk("s4_pend_kept", 8'(pending), 8'h04);
    step(4'b0000, 4'b0000, 0, 0);
    chk("s4_reassert", 8'(irq), 8'h01);
    chk("s4_terr_pulse", 8'(timeout_err), 8'h00);

    // New event on the bit being acknowledged wins
    step(4'b0100, 4'b0000, 1, 0);
    chk("s5_set_wins", 8'(pending), 8'h04);
    step(4'b0100, 4'b0000, 0, 1);
    step(4'b0100, 4'b0000, 0, 0);
    step(4'b0100, 4'b0000, 1, 0);

    // Reset mid-service with requests held high across release
    step(4'b1111, 4'b0000, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6_rst_irq", 8'(irq), 8'h00);
    chk("s6_rst_pend", 8'(pending), 8'h00);
    chk("s6_rst_svc", 8'(in_service), 8'h00);
    compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 4'b0000, 0, 0);
      chk("s6_no_event", 8'(pending), 8'h00);
    end
    step(4'b0000, 4'b0000, 0, 0);
    step(4'b0001, 4'b0000, 0, 0);
    chk("s6_toggle_event", 8'(pending), 8'h01);

    // Random traffic
    r   = 4'b0001;
    msk = 4'b0000;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) == 0) r = r ^ 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) msk = 4'($urandom_range(0, 15));
      step(r, msk, ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
